// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 burst master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_burst_pkg;

    // One-hot so every bus VALID/READY decodes straight from a single state flop.
    typedef enum logic [7:0] {
        ST_IDLE    = 8'b0000_0001,
        ST_CHECK   = 8'b0000_0010,
        ST_WR_ADDR = 8'b0000_0100,
        ST_WR_DATA = 8'b0000_1000,
        ST_WR_RESP = 8'b0001_0000,
        ST_RD_ADDR = 8'b0010_0000,
        ST_RD_DATA = 8'b0100_0000,
        ST_DONE    = 8'b1000_0000
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam int         BOUNDARY_4K = 12;

    // Ceiling log2; used with power-of-two byte counts to get AxSIZE.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 full bus bundle (AW/W/B/AR/R) between the burst master and a slave.
// Latency: n/a (wires only).
// Backpressure: standard AXI VALID/READY on every channel.
// Ports: master modport drives AW/W/AR channels and B/R READY; slave modport the reverse.
interface axi_burst_master_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     M_AXI_AWID;
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]              M_AXI_AWLEN;
    logic [2:0]              M_AXI_AWSIZE;
    logic [1:0]              M_AXI_AWBURST;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;

    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WLAST;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;

    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    logic [ID_WIDTH-1:0]     M_AXI_ARID;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [7:0]              M_AXI_ARLEN;
    logic [2:0]              M_AXI_ARSIZE;
    logic [1:0]              M_AXI_ARBURST;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;

    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RLAST;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axi_burst_pattern.sv
// Beat counter and incrementing data pattern (seed + i) shared by the W and R paths.
// Latency: pattern word valid the cycle after load; advances one word per accepted beat.
// Backpressure: holds data/last while beat is low.
// Ports: load/seed restart the pattern, beat advances it, data is the current word,
//        last flags beat index == len.
module axi_burst_pattern #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [7:0]            len,
    input  logic                  beat,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    logic [7:0]            cnt_q;
    logic [DATA_WIDTH-1:0] data_q;

    // The running word is kept as a register rather than seed+cnt so no wide adder
    // sits on the counter output; wrap modulo 2^DATA_WIDTH is natural.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else if (load) begin
            cnt_q  <= '0;
            data_q <= seed;
        end else if (beat) begin
            cnt_q  <= cnt_q + 8'd1;
            data_q <= data_q + DATA_WIDTH'(1);
        end
    end

    assign data = data_q;
    assign last = (cnt_q == len);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master running one INCR burst per command: writes seed+i, or reads and compares to seed+i.
// Latency: done 2 cycles after accept on a 4KB reject; otherwise bus-limited, 1 idle cycle between commands.
// Backpressure: cmd_ready only in IDLE; VALIDs held until READY; W stream stalls cleanly on WREADY.
// Ports: M_AXI_ACLK/M_AXI_ARESETN; cmd_* command port; done/done_err/mismatch_cnt status;
//        m_axi AXI4 master bus.
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter     C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
    parameter int C_M_AXI_ID_WIDTH           = 1,
    parameter int C_M_AXI_ADDR_WIDTH         = 32,
    parameter int C_M_AXI_DATA_WIDTH         = 32,
    parameter int C_MISMATCH_W               = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_seed,
    output logic                          done,
    output logic                          done_err,
    output logic [C_MISMATCH_W-1:0]       mismatch_cnt,
    axi_burst_master_if.master            m_axi
);

    localparam int AW        = C_M_AXI_ADDR_WIDTH;
    localparam int DW        = C_M_AXI_DATA_WIDTH;
    localparam int BYTES     = DW / 8;
    localparam int AXI_SIZE  = clogb2(BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);
    localparam logic [AW-1:0] BASE_ADDR  = AW'(C_M_TARGET_SLAVE_BASE_ADDR);

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q;
    logic [7:0]              len_q;
    logic                    write_q;
    logic                    err_q;
    logic [C_MISMATCH_W-1:0] mm_q;

    logic          load, beat;
    logic          aw_vld, w_vld, b_rdy, ar_vld, r_rdy;
    logic          b_hs, r_hs;
    logic [DW-1:0] pat_data;
    logic          pat_last;
    logic [AW-1:0] burst_bytes, end_addr;
    logic          cross_4k;

    axi_burst_pattern #(.DATA_WIDTH(DW)) u_pattern (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .load          (load),
        .seed          (cmd_seed),
        .len           (len_q),
        .beat          (beat),
        .data          (pat_data),
        .last          (pat_last)
    );

    // Last byte touched by the burst; a change in the bits above the 4KB page
    // offset means the burst would cross a page, which AXI forbids.
    assign burst_bytes = (AW'(len_q) + AW'(1)) << AXI_SIZE;
    assign end_addr    = addr_q + burst_bytes - AW'(1);
    assign cross_4k    = (end_addr[AW-1:BOUNDARY_4K] != addr_q[AW-1:BOUNDARY_4K]);

    assign b_hs = b_rdy && m_axi.M_AXI_BVALID;
    assign r_hs = r_rdy && m_axi.M_AXI_RVALID;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        load      = 1'b0;
        beat      = 1'b0;
        aw_vld    = 1'b0;
        w_vld     = 1'b0;
        b_rdy     = 1'b0;
        ar_vld    = 1'b0;
        r_rdy     = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cross_4k)     state_d = ST_DONE;
                else if (write_q) state_d = ST_WR_ADDR;
                else              state_d = ST_RD_ADDR;
            end
            ST_WR_ADDR: begin
                aw_vld = 1'b1;
                if (m_axi.M_AXI_AWREADY) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                w_vld = 1'b1;
                beat  = m_axi.M_AXI_WREADY;
                if (m_axi.M_AXI_WREADY && pat_last) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                b_rdy = 1'b1;
                if (m_axi.M_AXI_BVALID) state_d = ST_DONE;
            end
            ST_RD_ADDR: begin
                ar_vld = 1'b1;
                if (m_axi.M_AXI_ARREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                r_rdy = 1'b1;
                beat  = m_axi.M_AXI_RVALID;
                // Leave on RLAST even if early, or on the final beat if RLAST never comes.
                if (m_axi.M_AXI_RVALID && (m_axi.M_AXI_RLAST || pat_last)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q  <= '0;
            len_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            mm_q    <= '0;
        end else begin
            if (load) begin
                addr_q  <= BASE_ADDR + (cmd_addr & ALIGN_MASK);
                len_q   <= cmd_len;
                write_q <= cmd_write;
                err_q   <= 1'b0;
                mm_q    <= '0;
            end
            if (state_q == ST_CHECK && cross_4k) begin
                err_q <= 1'b1;
            end
            if (b_hs && m_axi.M_AXI_BRESP != RESP_OKAY) begin
                err_q <= 1'b1;
            end
            if (r_hs) begin
                // Sticky: any bad response or RLAST disagreeing with the beat count.
                if (m_axi.M_AXI_RRESP != RESP_OKAY || m_axi.M_AXI_RLAST != pat_last) begin
                    err_q <= 1'b1;
                end
                if (m_axi.M_AXI_RDATA != pat_data && mm_q != '1) begin
                    mm_q <= mm_q + C_MISMATCH_W'(1);
                end
            end
        end
    end

    assign done_err     = done && err_q;
    assign mismatch_cnt = mm_q;

    assign m_axi.M_AXI_AWID    = '0;
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWLEN   = len_q;
    assign m_axi.M_AXI_AWSIZE  = 3'(AXI_SIZE);
    assign m_axi.M_AXI_AWBURST = BURST_INCR;
    assign m_axi.M_AXI_AWVALID = aw_vld;

    assign m_axi.M_AXI_WDATA   = pat_data;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WLAST   = w_vld && pat_last;
    assign m_axi.M_AXI_WVALID  = w_vld;

    assign m_axi.M_AXI_BREADY  = b_rdy;

    assign m_axi.M_AXI_ARID    = '0;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARLEN   = len_q;
    assign m_axi.M_AXI_ARSIZE  = 3'(AXI_SIZE);
    assign m_axi.M_AXI_ARBURST = BURST_INCR;
    assign m_axi.M_AXI_ARVALID = ar_vld;

    assign m_axi.M_AXI_RREADY  = r_rdy;

endmodule
